// File: rtl/vga_defs.sv
// vga_defs: shared definitions for the VGA timing core.
//   - 640x480@60 timing constants used as default parameter values
//   - default colour channel widths
//   - helpers for packed {R,G,B} field offsets and range decoding
//   - per-pixel flag bundle carried through the sync/colour delay line
package vga_defs;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_R_W = 3;
    localparam int DEF_G_W = 3;
    localparam int DEF_B_W = 2;

    // Flags describing one pixel position as it travels towards the pins.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } vga_flags_t;

    // Bit offset of the red field in a packed {R,G,B} word.
    function automatic int red_ofs(input int g_w, input int b_w);
        return g_w + b_w;
    endfunction

    // Bit offset of the green field in a packed {R,G,B} word.
    function automatic int green_ofs(input int b_w);
        return b_w;
    endfunction

    // True when lo <= v < hi.
    function automatic logic in_span(input int unsigned v, input int unsigned lo,
                                     input int unsigned hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrapping counter for one display axis (h or v).
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance by one position
//   cnt      : current position, wraps LIMIT -> 0; resets to LIMIT so the
//              first enable lands on position 0
//   tc       : cnt is at LIMIT (next enable wraps)
//   active   : cnt < ACT_END
//   sync     : SYNC_START <= cnt < SYNC_END
// active/sync are registered together with cnt, so they always describe
// the position currently held in cnt.
module vga_axis_counter
    import vga_defs::*;
#(
    parameter int CNT_W      = 10,
    parameter int LIMIT      = 799,
    parameter int ACT_END    = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc,
    output logic             active,
    output logic             sync
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             tc_s;
    logic             active_r;
    logic             sync_r;

    // Terminal count and next position.
    always_comb begin
        tc_s = (cnt_r == CNT_W'(LIMIT));
        if (tc_s) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Position register with decode of the position being loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= CNT_W'(LIMIT);
            active_r <= 1'b0;
            sync_r   <= 1'b0;
        end else if (en) begin
            cnt_r    <= cnt_next_s;
            active_r <= in_span(int'(cnt_next_s), 0, ACT_END);
            sync_r   <= in_span(int'(cnt_next_s), SYNC_START, SYNC_END);
        end else begin
            cnt_r    <= cnt_r;
            active_r <= active_r;
            sync_r   <= sync_r;
        end
    end

    assign cnt    = cnt_r;
    assign tc     = tc_s;
    assign active = active_r;
    assign sync   = sync_r;

endmodule

// File: rtl/vga_timing_core.sv
// vga_timing_core: parametrised VGA timing generator.
//   clk, rst     : board clock, asynchronous active-high reset
//   color_in     : packed {R,G,B} from the pixel generator
//   test_mode    : select built-in colour bars (VGA_TEST_PATTERN_EN only)
//   req          : position on col/row is in the active area
//   col, row     : raw horizontal / vertical counters
//   frame_start  : one-clk pulse after the pixel tick that loads (0,0)
//   vga_red/green/blue, h_sync, v_sync : display pins
// Sync and colour for a position reach the pins PIX_LAT pixel ticks after
// the position is requested, giving the pixel generator that long to answer.
// Optional macro VGA_TEST_PATTERN_EN adds an 8-bar test pattern that is
// substituted for color_in when test_mode=1.
module vga_timing_core
    import vga_defs::*;
#(
    parameter int   CLK_DIV  = 2,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   PIX_LAT  = 2,
    parameter int   CNT_W    = 10,
    parameter int   R_W      = DEF_R_W,
    parameter int   G_W      = DEF_G_W,
    parameter int   B_W      = DEF_B_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [R_W+G_W+B_W-1:0] color_in,
    input  logic                   test_mode,
    output logic                   req,
    output logic [CNT_W-1:0]       col,
    output logic [CNT_W-1:0]       row,
    output logic                   frame_start,
    output logic [R_W-1:0]         vga_red,
    output logic [G_W-1:0]         vga_green,
    output logic [B_W-1:0]         vga_blue,
    output logic                   h_sync,
    output logic                   v_sync
);

    localparam int PIX_W   = R_W + G_W + B_W;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int R_OFS   = red_ofs(G_W, B_W);
    localparam int G_OFS   = green_ofs(B_W);

    logic [DIV_W-1:0]  div_r;
    logic              pix_ce_s;
    logic [CNT_W-1:0]  h_cnt_s;
    logic [CNT_W-1:0]  v_cnt_s;
    logic              h_tc_s;
    logic              v_tc_s;
    logic              h_act_s;
    logic              v_act_s;
    logic              h_syn_s;
    logic              v_syn_s;
    logic              v_en_s;
    logic              req_s;
    logic              frame_start_r;
    logic [PIX_W-1:0]  pix_src_s;
    logic [PIX_W-1:0]  color_r;

    vga_flags_t [PIX_LAT-1:0] dly_r;
    vga_flags_t [PIX_LAT-1:0] dly_next_s;

    // Pixel-clock enable: high on the last cycle of each CLK_DIV period.
    always_comb begin
        pix_ce_s = (div_r == DIV_W'(CLK_DIV - 1));
        v_en_s   = pix_ce_s & h_tc_s;
        req_s    = h_act_s & v_act_s;
    end

    // Clock divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= {DIV_W{1'b0}};
        end else if (pix_ce_s) begin
            div_r <= {DIV_W{1'b0}};
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    vga_axis_counter #(
        .CNT_W      (CNT_W),
        .LIMIT      (H_TOTAL - 1),
        .ACT_END    (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
    ) u_h_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (pix_ce_s),
        .cnt    (h_cnt_s),
        .tc     (h_tc_s),
        .active (h_act_s),
        .sync   (h_syn_s)
    );

    vga_axis_counter #(
        .CNT_W      (CNT_W),
        .LIMIT      (V_TOTAL - 1),
        .ACT_END    (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
    ) u_v_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (v_en_s),
        .cnt    (v_cnt_s),
        .tc     (v_tc_s),
        .active (v_act_s),
        .sync   (v_syn_s)
    );

    // Delay-line inputs: stage 0 takes the current position's flags.
    always_comb begin
        dly_next_s[0] = '{active: req_s, hs: h_syn_s, vs: v_syn_s};
        for (int i = 1; i < PIX_LAT; i++) begin
            dly_next_s[i] = dly_r[i-1];
        end
    end

    // Sync/active delay line, shifted once per pixel tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_r <= '0;
        end else if (pix_ce_s) begin
            dly_r <= dly_next_s;
        end else begin
            dly_r <= dly_r;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]               bar_s;
    logic [PIX_LAT-1:0][2:0]  bar_r;
    logic [PIX_LAT-1:0][2:0]  bar_next_s;

    // Bar index 0..7 of the requested column, by threshold counting.
    always_comb begin
        bar_s = 3'd0;
        for (int i = 1; i < 8; i++) begin
            bar_s = bar_s + ((h_cnt_s >= CNT_W'(i * BAR_W)) ? 3'd1 : 3'd0);
        end
        bar_next_s[0] = bar_s;
        for (int i = 1; i < PIX_LAT; i++) begin
            bar_next_s[i] = bar_r[i-1];
        end
    end

    // Bar index travels alongside the sync flags so the pattern shares their latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_r <= '0;
        end else if (pix_ce_s) begin
            bar_r <= bar_next_s;
        end else begin
            bar_r <= bar_r;
        end
    end

    // Bar index bits {2,1,0} switch {R,G,B} fully on or off.
    function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] b);
        return {{R_W{b[2]}}, {G_W{b[1]}}, {B_W{b[0]}}};
    endfunction

    // Colour source: test bars or pixel generator.
    always_comb begin
        if (test_mode) begin
            pix_src_s = bar_color(bar_next_s[PIX_LAT-1]);
        end else begin
            pix_src_s = color_in;
        end
    end
`else
    logic unused_test_mode_s;

    // Colour source: pixel generator only.
    always_comb begin
        pix_src_s          = color_in;
        unused_test_mode_s = test_mode;
    end
`endif

    // Colour register: sampled on the tick the position reaches the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_r <= {PIX_W{1'b0}};
        end else if (pix_ce_s) begin
            if (dly_next_s[PIX_LAT-1].active) begin
                color_r <= pix_src_s;
            end else begin
                color_r <= {PIX_W{1'b0}};
            end
        end else begin
            color_r <= color_r;
        end
    end

    // Frame-start pulse for the cycle following the tick that loads (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= pix_ce_s & h_tc_s & v_tc_s;
        end
    end

    assign req         = req_s;
    assign col         = h_cnt_s;
    assign row         = v_cnt_s;
    assign frame_start = frame_start_r;
    assign vga_red     = color_r[R_OFS +: R_W];
    assign vga_green   = color_r[G_OFS +: G_W];
    assign vga_blue    = color_r[0 +: B_W];
    // XNOR with the polarity: flag set drives the active level.
    assign h_sync      = dly_r[PIX_LAT-1].hs ~^ H_POL;
    assign v_sync      = dly_r[PIX_LAT-1].vs ~^ V_POL;

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed testbench for vga_timing_core using a reduced raster
// (24 ticks x 8 lines) so whole frames fit in a short run.
//   Instance A: CLK_DIV=2, PIX_LAT=2.  Instance B: CLK_DIV=1, PIX_LAT=3.
// Horizontal: active 0..15, sync 18..21. Vertical: active 0..3, sync 5..6.
module tb_vga_timing_core;

    logic       clk;
    logic       rst;
    logic [7:0] a_cin;
    logic [7:0] b_cin;
    logic       test_mode;

    logic       a_req, a_fs, a_hs, a_vs;
    logic [9:0] a_col, a_row;
    logic [2:0] a_r, a_g;
    logic [1:0] a_b;
    logic       b_req, b_fs, b_hs, b_vs;
    logic [9:0] b_col, b_row;
    logic [2:0] b_r, b_g;
    logic [1:0] b_b;

    int total  = 0;
    int passed = 0;
    int edge_n = 0;

    vga_timing_core #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIX_LAT(2)
    ) dut_a (
        .clk(clk), .rst(rst), .color_in(a_cin), .test_mode(test_mode),
        .req(a_req), .col(a_col), .row(a_row), .frame_start(a_fs),
        .vga_red(a_r), .vga_green(a_g), .vga_blue(a_b),
        .h_sync(a_hs), .v_sync(a_vs)
    );

    vga_timing_core #(
        .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIX_LAT(3)
    ) dut_b (
        .clk(clk), .rst(rst), .color_in(b_cin), .test_mode(test_mode),
        .req(b_req), .col(b_col), .row(b_row), .frame_start(b_fs),
        .vga_red(b_r), .vga_green(b_g), .vga_blue(b_b),
        .h_sync(b_hs), .v_sync(b_vs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to posedge number e after release, then settle 1 time unit.
    task automatic to_edge(input int e);
        while (edge_n < e) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    initial begin
        int hs_lo, vs_lo, req_hi, col_nz, fs_cnt;
        logic [7:0] exp_a, exp_b;

        rst       = 1'b1;
        a_cin     = 8'hE0;
        b_cin     = 8'hFF;
        test_mode = 1'b0;

        // Reset state
        repeat (10) @(posedge clk);
        #1;
        check("rst_req",   32'(a_req), 32'd0);
        check("rst_hs",    32'(a_hs), 32'd1);
        check("rst_vs",    32'(a_vs), 32'd1);
        check("rst_color", 32'({a_r, a_g, a_b}), 32'h0);
        check("rst_fs",    32'(a_fs), 32'd0);
        check("rst_col",   32'(a_col), 32'd23);
        check("rst_row",   32'(a_row), 32'd7);

        @(negedge clk);
        rst    = 1'b0;
        edge_n = 0;

        // B (CLK_DIV=1) loads (0,0) on the first edge
        to_edge(1);
        check("b_fs_e1",  32'(b_fs), 32'd1);
        check("b_req_e1", 32'(b_req), 32'd1);
        check("a_fs_e1",  32'(a_fs), 32'd0);

        // A loads (0,0) on edge 2
        to_edge(2);
        check("a_fs_e2",  32'(a_fs), 32'd1);
        check("a_col_e2", 32'(a_col), 32'd0);
        check("a_row_e2", 32'(a_row), 32'd0);
        check("a_req_e2", 32'(a_req), 32'd1);
        check("b_fs_e2",  32'(b_fs), 32'd0);
        check("b_col_e2", 32'(b_col), 32'd1);

        to_edge(3);
        check("a_fs_e3",    32'(a_fs), 32'd0);
        check("a_col_e3",   32'(a_col), 32'd0);
        check("b_color_e3", 32'({b_r, b_g, b_b}), 32'h00);

        // B colour appears 3 clk after req rises
        to_edge(4);
        check("b_color_e4", 32'({b_r, b_g, b_b}), 32'hFF);

        // A colour appears 2 ticks (4 clk) after req rises
        to_edge(5);
        check("a_red_e5", 32'(a_r), 32'd0);
        to_edge(6);
        check("a_red_e6",   32'(a_r), 32'd7);
        check("a_green_e6", 32'(a_g), 32'd0);

        // B: req falls at edge 17, last pixel colour ends at edge 20
        to_edge(17);
        check("b_req_e17", 32'(b_req), 32'd0);
        to_edge(19);
        check("b_color_e19", 32'({b_r, b_g, b_b}), 32'hFF);
        to_edge(20);
        check("b_color_e20", 32'({b_r, b_g, b_b}), 32'h00);

        // A: req falls at edge 34, last pixel colour at 36..37, blank at 38
        to_edge(34);
        check("a_req_e34", 32'(a_req), 32'd0);
        to_edge(37);
        check("a_red_e37", 32'(a_r), 32'd7);
        to_edge(38);
        check("a_red_e38", 32'(a_r), 32'd0);

        // A h_sync low for pin ticks 20..23 (edges 42..49)
        to_edge(41);
        check("a_hs_e41", 32'(a_hs), 32'd1);
        to_edge(42);
        check("a_hs_e42", 32'(a_hs), 32'd0);
        to_edge(49);
        check("a_hs_e49", 32'(a_hs), 32'd0);
        to_edge(50);
        check("a_hs_e50", 32'(a_hs), 32'd1);

        // A v_sync low for pin ticks 122..169 (edges 246..341)
        to_edge(245);
        check("a_vs_e245", 32'(a_vs), 32'd1);
        to_edge(246);
        check("a_vs_e246", 32'(a_vs), 32'd0);
        to_edge(341);
        check("a_vs_e341", 32'(a_vs), 32'd0);
        to_edge(342);
        check("a_vs_e342", 32'(a_vs), 32'd1);

        // Second frame starts exactly 384 clk later
        to_edge(386);
        check("a_fs_e386", 32'(a_fs), 32'd1);
        check("a_col_e386", 32'(a_col), 32'd0);
        check("a_row_e386", 32'(a_row), 32'd0);

        // One full frame of A: duty counts
        hs_lo = 0; vs_lo = 0; req_hi = 0; col_nz = 0; fs_cnt = 0;
        for (int i = 0; i < 384; i++) begin
            @(posedge clk);
            edge_n++;
            #1;
            if (!a_hs) hs_lo++;
            if (!a_vs) vs_lo++;
            if (a_req) req_hi++;
            if ({a_r, a_g, a_b} != 8'h00) col_nz++;
            if (a_fs) fs_cnt++;
        end
        check("frame_hs_low",   32'(hs_lo), 32'd64);
        check("frame_vs_low",   32'(vs_lo), 32'd96);
        check("frame_req_high", 32'(req_hi), 32'd128);
        check("frame_color_nz", 32'(col_nz), 32'd128);
        check("frame_fs_count", 32'(fs_cnt), 32'd1);
        check("a_fs_e770",      32'(a_fs), 32'd1);

        // Varying colour input
        a_cin = 8'h1D;
        to_edge(775);
        check("a_color_1d", 32'({a_r, a_g, a_b}), 32'h1D);
        check("a_green_1d", 32'(a_g), 32'd7);
        a_cin = 8'h6A;
        to_edge(777);
        check("a_red_6a",   32'(a_r), 32'd3);
        check("a_green_6a", 32'(a_g), 32'd2);
        check("a_blue_6a",  32'(a_b), 32'd2);

        // Mid-frame reset at A position (10,2)
        to_edge(886);
        check("a_col_pre_rst", 32'(a_col), 32'd10);
        check("a_row_pre_rst", 32'(a_row), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_req",   32'(a_req), 32'd0);
        check("mrst_hs",    32'(a_hs), 32'd1);
        check("mrst_vs",    32'(a_vs), 32'd1);
        check("mrst_color", 32'({a_r, a_g, a_b}), 32'h0);
        check("mrst_col",   32'(a_col), 32'd23);
        check("mrst_row",   32'(a_row), 32'd7);
        check("mrst_b_col", 32'(b_col), 32'd23);
        @(negedge clk);
        rst       = 1'b0;
        edge_n    = 0;
        test_mode = 1'b1;

        to_edge(2);
        check("restart_fs",  32'(a_fs), 32'd1);
        check("restart_col", 32'(a_col), 32'd0);
        check("restart_row", 32'(a_row), 32'd0);

        // B at edge 4 shows h=0 (bar 0)
`ifdef VGA_TEST_PATTERN_EN
        exp_b = 8'h00;
`else
        exp_b = 8'hFF;
`endif
        to_edge(4);
        check("tp_b_h0", 32'({b_r, b_g, b_b}), 32'(exp_b));

        // A at edge 6 shows h=0 (bar 0)
`ifdef VGA_TEST_PATTERN_EN
        exp_a = 8'h00;
`else
        exp_a = 8'h6A;
`endif
        to_edge(6);
        check("tp_a_h0", 32'({a_r, a_g, a_b}), 32'(exp_a));

        // A at edge 11 shows h=2 (bar 1: blue only)
`ifdef VGA_TEST_PATTERN_EN
        exp_a = 8'h03;
`else
        exp_a = 8'h6A;
`endif
        to_edge(11);
        check("tp_a_h2", 32'({a_r, a_g, a_b}), 32'(exp_a));

        // A at edge 37 shows h=15 (bar 7: all on)
`ifdef VGA_TEST_PATTERN_EN
        exp_a = 8'hFF;
`else
        exp_a = 8'h6A;
`endif
        to_edge(37);
        check("tp_a_h15", 32'({a_r, a_g, a_b}), 32'(exp_a));
        to_edge(38);
        check("tp_a_blank", 32'({a_r, a_g, a_b}), 32'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
